// File: rtl/demux_n.sv
// Clocked 4-phase demultiplexer: routes one bundled-data input token to one of M
// outputs (or all of them in broadcast mode), selected by a 4-phase control channel.
module demux_n #(
  parameter int unsigned N     = 32,
  parameter int unsigned M     = 4,
  parameter int unsigned SW    = 3,
  parameter bit          BCAST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_i,
  output logic          a_i,
  input  logic [N-1:0]  d_i,
  input  logic          ctl_r,
  input  logic [SW-1:0] ctl_sel,
  output logic          actl_i,
  output logic [M-1:0]  r_o,
  input  logic [M-1:0]  a_o,
  output logic [N-1:0]  d_o,
  output logic          err_o
);

  localparam int unsigned SEL_BCAST = (1 << SW) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RTZ  = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] sel_q;
  logic [M-1:0]  tgt_c;
  logic [M-1:0]  new_tgt_c;

  // Target mask: one-hot for an in-range index, all ones for broadcast, zero if invalid.
  function automatic logic [M-1:0] decode(input logic [SW-1:0] s);
    logic [M-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (s == SW'(i)) mask[i] = 1'b1;
    end
    if (BCAST && (s == SW'(SEL_BCAST))) mask = '1;
    return mask;
  endfunction

  always_comb begin
    tgt_c     = decode(sel_q);
    new_tgt_c = decode(ctl_sel);
  end

  // Both acknowledges are the same registered flag.
  assign actl_i = a_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel_q <= '0;
      a_i   <= 1'b0;
      r_o   <= '0;
      d_o   <= '0;
      err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r_i && ctl_r) begin
            d_o   <= d_i;
            sel_q <= ctl_sel;
            if (new_tgt_c != '0) begin
              r_o   <= new_tgt_c;
              state <= FWD;
            end else begin
              // Invalid select: token is dropped but still acknowledged.
              err_o <= 1'b1;
              a_i   <= 1'b1;
              state <= RTZ;
            end
          end
        end
        FWD: begin
          if ((a_o & tgt_c) == tgt_c) begin
            r_o   <= '0;
            a_i   <= 1'b1;
            state <= RTZ;
          end
        end
        RTZ: begin
          // Producer, control and consumer return-to-zero may finish in any order.
          if (!r_i && !ctl_r && ((a_o & tgt_c) == '0)) begin
            a_i   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          r_o   <= '0;
          a_i   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_n.sv
// Directed bench for demux_n: routing, broadcast, invalid select, partial
// request, return-to-zero ordering and asynchronous reset mid-token.
module tb_demux_n;

  localparam int unsigned N  = 32;
  localparam int unsigned M  = 4;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          rst;
  logic          r_i;
  logic          a_i;
  logic [N-1:0]  d_i;
  logic          ctl_r;
  logic [SW-1:0] ctl_sel;
  logic          actl_i;
  logic [M-1:0]  r_o;
  logic [M-1:0]  a_o;
  logic [N-1:0]  d_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  demux_n #(.N(N), .M(M), .SW(SW), .BCAST(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .r_i     (r_i),
    .a_i     (a_i),
    .d_i     (d_i),
    .ctl_r   (ctl_r),
    .ctl_sel (ctl_sel),
    .actl_i  (actl_i),
    .r_o     (r_o),
    .a_o     (a_o),
    .d_o     (d_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; r_i = 1'b0; ctl_r = 1'b0; ctl_sel = '0; d_i = '0; a_o = '0;
    #2;
    chk("rst_r_o", 64'(r_o), 64'h0);
    chk("rst_a_i", 64'(a_i), 64'h0);
    chk("rst_actl", 64'(actl_i), 64'h0);
    chk("rst_d_o", 64'(d_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    step(); step();
    rst = 1'b1;
    step();

    // Route to output 2
    ctl_sel = 3'd2; d_i = 32'hDEADBEEF; r_i = 1'b1; ctl_r = 1'b1;
    step();
    chk("route_r_o", 64'(r_o), 64'h4);
    chk("route_d_o", 64'(d_o), 64'hDEADBEEF);
    chk("route_a_i0", 64'(a_i), 64'h0);
    a_o = 4'b0100;
    step();
    chk("route_ack_r_o", 64'(r_o), 64'h0);
    chk("route_ack_a_i", 64'(a_i), 64'h1);
    chk("route_ack_actl", 64'(actl_i), 64'h1);
    r_i = 1'b0; ctl_r = 1'b0; a_o = '0;
    step();
    chk("route_rtz_a_i", 64'(a_i), 64'h0);
    chk("route_rtz_actl", 64'(actl_i), 64'h0);
    step();
    chk("route_idle_r_o", 64'(r_o), 64'h0);

    // Broadcast; select changes after capture are ignored
    ctl_sel = 3'd7; d_i = 32'h12345678; r_i = 1'b1; ctl_r = 1'b1;
    step();
    chk("bc_r_o", 64'(r_o), 64'hF);
    chk("bc_d_o", 64'(d_o), 64'h12345678);
    ctl_sel = 3'd0;
    a_o = 4'b1011;
    step();
    chk("bc_part_a_i", 64'(a_i), 64'h0);
    chk("bc_part_r_o", 64'(r_o), 64'hF);
    step();
    chk("bc_part2_a_i", 64'(a_i), 64'h0);
    a_o = 4'b1111;
    step();
    chk("bc_done_a_i", 64'(a_i), 64'h1);
    chk("bc_done_r_o", 64'(r_o), 64'h0);
    r_i = 1'b0; ctl_r = 1'b0; a_o = '0;
    step();
    chk("bc_rtz_a_i", 64'(a_i), 64'h0);
    chk("bc_err", 64'(err_o), 64'h0);

    // Invalid select 5 is dropped and flagged
    ctl_sel = 3'd5; d_i = 32'h0BADF00D; r_i = 1'b1; ctl_r = 1'b1;
    step();
    chk("inv_err", 64'(err_o), 64'h1);
    chk("inv_r_o", 64'(r_o), 64'h0);
    chk("inv_a_i", 64'(a_i), 64'h1);
    r_i = 1'b0; ctl_r = 1'b0;
    step();
    chk("inv_rtz_a_i", 64'(a_i), 64'h0);
    ctl_sel = 3'd0; d_i = 32'h0000A5A5; r_i = 1'b1; ctl_r = 1'b1;
    step();
    chk("inv_next_r_o", 64'(r_o), 64'h1);
    chk("inv_next_d_o", 64'(d_o), 64'hA5A5);
    chk("inv_next_err", 64'(err_o), 64'h1);
    a_o = 4'b0001;
    step();
    chk("inv_next_a_i", 64'(a_i), 64'h1);
    r_i = 1'b0; ctl_r = 1'b0; a_o = '0;
    step();
    chk("inv_next_rtz", 64'(a_i), 64'h0);

    // Partial request is held without effect
    ctl_sel = 3'd1; d_i = 32'h55AA55AA; r_i = 1'b1; ctl_r = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("part_r_o", 64'(r_o), 64'h0);
      chk("part_a_i", 64'(a_i), 64'h0);
    end
    ctl_r = 1'b1;
    step();
    chk("part_acc_r_o", 64'(r_o), 64'h2);
    chk("part_acc_d_o", 64'(d_o), 64'h55AA55AA);
    a_o = 4'b0010;
    step();
    chk("part_ack_a_i", 64'(a_i), 64'h1);

    // RTZ order A: requests fall first, consumer ack 3 cycles later
    r_i = 1'b0; ctl_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rtzA_hold", 64'(a_i), 64'h1);
    end
    a_o = '0;
    step();
    chk("rtzA_fall", 64'(a_i), 64'h0);

    // RTZ order B: consumer ack falls first, requests 3 cycles later
    ctl_sel = 3'd1; d_i = 32'h01020304; r_i = 1'b1; ctl_r = 1'b1;
    step();
    chk("rtzB_r_o", 64'(r_o), 64'h2);
    a_o = 4'b0010;
    step();
    chk("rtzB_a_i", 64'(a_i), 64'h1);
    a_o = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rtzB_hold", 64'(a_i), 64'h1);
    end
    r_i = 1'b0; ctl_r = 1'b0;
    step();
    chk("rtzB_fall", 64'(a_i), 64'h0);

    // Reset asserted mid-FWD, requests held across release
    ctl_sel = 3'd1; d_i = 32'hCAFEF00D; r_i = 1'b1; ctl_r = 1'b1;
    step();
    chk("mid_r_o", 64'(r_o), 64'h2);
    rst = 1'b0;
    #1;
    chk("mid_rst_r_o", 64'(r_o), 64'h0);
    chk("mid_rst_a_i", 64'(a_i), 64'h0);
    chk("mid_rst_d_o", 64'(d_o), 64'h0);
    chk("mid_rst_err", 64'(err_o), 64'h0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_r_o", 64'(r_o), 64'h2);
    chk("post_rst_d_o", 64'(d_o), 64'hCAFEF00D);
    a_o = 4'b0010;
    step();
    chk("post_rst_a_i", 64'(a_i), 64'h1);
    r_i = 1'b0; ctl_r = 1'b0; a_o = '0;
    step();
    chk("post_rst_rtz", 64'(a_i), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
